// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART timing constants and the pacing FSM state type for uart_tx_fifo.
// uart_tx derives its bit period from the same values, which keeps the two blocks consistent.
package uart_tx_fifo_pkg;

    localparam int FPGA_FREQ  = 50_000_000;
    localparam int BAUD_RATE  = 9600;
`ifdef SIM
    localparam int BAUD_END   = 56;
`else
    localparam int BAUD_END   = FPGA_FREQ / BAUD_RATE;
`endif
    localparam int FRAME_BITS = 10;

    // One guard bit after each 10-bit frame gives uart_tx time to return to idle.
    localparam int FRAME_CYCLES_DEF = BAUD_END * (FRAME_BITS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: register-array storage, wrapping pointers, occupancy level and flags.
// The push input must already be qualified by the caller; a push while full is not guarded here.
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [7:0]        wr_data,
    input  logic              pop,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // NOTE: the storage array has no reset; its contents only matter once level says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == (ADDR_W + 1)'(DEPTH));
    assign empty   = (level == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx that emits one tx_trig pulse per byte, spaced by a fixed frame time.
// uart_tx has no busy output, so pacing relies purely on the frame counter.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int FRAME_CYCLES = uart_tx_fifo_pkg::FRAME_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic              busy,
    output logic              tx_trig,
    output logic [7:0]        tx_data
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 2);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             pop;
    logic             push;
    logic [7:0]       rd_data;

    // A write to a full FIFO still fits when the pacing FSM pops in the same cycle.
    assign push = wr_en && (!full || pop);

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty)          next_state = WAIT;
            WAIT:    if (cnt == CNT_LAST) next_state = IDLE;
            default:                      next_state = IDLE;
        endcase
    end

    always_comb begin
        pop  = (state == IDLE) && !empty;
        busy = (state == WAIT);
    end

    // tx_data is loaded only on a pop, so it is held stable for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            tx_trig <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            tx_trig <= pop;
            if (pop) begin
                tx_data <= rd_data;
                cnt     <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Set has priority over clear so an overflow in the clearing cycle is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           ovf <= 1'b0;
        else if (wr_en && full && !pop)    ovf <= 1'b1;
        else if (ovf_clr)                  ovf <= 1'b0;
    end

endmodule
